// File: rtl/regfile_dump_reader_if.sv
// Dump stream interface: one register (or condition-bit) beat per valid/ready handshake.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              cb;
  logic              last;

  modport master (output valid, output data, output addr, output cb, output last, input ready);
  modport slave  (input valid, input data, input addr, input cb, input last, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Regfile dump engine: walks every register through the rs read port, optionally
// appends the condition bit, and streams the beats out. Freezes the core while busy.
module regfile_dump_reader #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int RF_DEPTH   = 8,
  parameter int INCLUDE_CB = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_W-1:0]     rf_addr_o,
  input  logic [DATA_W-1:0]     rf_data_i,
  input  logic                  cb_data_i,
  regfile_dump_reader_if.master dump,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RF_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_CB,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              valid_reg, valid_next;
  logic              cb_reg, cb_next;
  logic              last_reg, last_next;

  // State and beat registers; reset aborts any dump and clears all outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rf_addr_reg <= '0;
      data_reg    <= '0;
      addr_reg    <= '0;
      valid_reg   <= 1'b0;
      cb_reg      <= 1'b0;
      last_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rf_addr_reg <= rf_addr_next;
      data_reg    <= data_next;
      addr_reg    <= addr_next;
      valid_reg   <= valid_next;
      cb_reg      <= cb_next;
      last_reg    <= last_next;
    end
  end

  // Next-state logic: READ captures one register, SEND waits for the sink, CB adds the flag beat.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rf_addr_next = rf_addr_reg;
    data_next    = data_reg;
    addr_next    = addr_reg;
    valid_next   = valid_reg;
    cb_next      = cb_reg;
    last_next    = last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          cnt_next     = '0;
          rf_addr_next = '0;
          state_next   = ST_READ;
        end
      end

      ST_READ: begin
        // rf_addr_o already equals cnt here, so rf_data_i is the register's value.
        data_next  = rf_data_i;
        addr_next  = cnt_reg;
        cb_next    = 1'b0;
        last_next  = (INCLUDE_CB == 0) && (cnt_reg == LAST_ADDR);
        valid_next = 1'b1;
        state_next = ST_SEND;
      end

      ST_SEND: begin
        if (dump.ready) begin
          if (cnt_reg != LAST_ADDR) begin
            // Advance the read address together with the counter; it never wraps.
            cnt_next     = cnt_reg + 1'b1;
            rf_addr_next = cnt_reg + 1'b1;
            valid_next   = 1'b0;
            state_next   = ST_READ;
          end else if (INCLUDE_CB != 0) begin
            data_next  = {{(DATA_W-1){1'b0}}, cb_data_i};
            addr_next  = '0;
            cb_next    = 1'b1;
            last_next  = 1'b1;
            state_next = ST_CB;
          end else begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            state_next = ST_DONE;
          end
        end
      end

      ST_CB: begin
        if (dump.ready) begin
          valid_next = 1'b0;
          cb_next    = 1'b0;
          last_next  = 1'b0;
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rf_addr_o  = rf_addr_reg;
  assign dump.valid = valid_reg;
  assign dump.data  = data_reg;
  assign dump.addr  = addr_reg;
  assign dump.cb    = cb_reg;
  assign dump.last  = last_reg;
  assign busy_o     = (state_reg == ST_READ) || (state_reg == ST_SEND) || (state_reg == ST_CB);
  assign stall_o    = busy_o;
  assign done_o     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: one instance with the condition-bit beat, one without,
// each fed from a bench-side register array and checked against a beat-list model.
module tb_regfile_dump_reader;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NREG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   [2];
  logic          start   [2];
  logic [AW-1:0] rf_addr [2];
  logic [DW-1:0] rf_data [2];
  logic          cb_in   [2];
  logic          busy    [2];
  logic          stall   [2];
  logic          done    [2];
  logic          rdy     [2];
  logic          rmode   [2];
  logic [DW-1:0] rf      [2][NREG];

  logic          vld [2];
  logic [DW-1:0] dat [2];
  logic [AW-1:0] adr [2];
  logic          cbo [2];
  logic          lst [2];

  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dif0 ();
  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dif1 ();

  regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RF_DEPTH(NREG), .INCLUDE_CB(1)) dut0 (
    .clk_i(clk), .reset_i(rst_n[0]), .start_i(start[0]), .rf_addr_o(rf_addr[0]),
    .rf_data_i(rf_data[0]), .cb_data_i(cb_in[0]), .dump(dif0),
    .busy_o(busy[0]), .stall_o(stall[0]), .done_o(done[0]));

  regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RF_DEPTH(NREG), .INCLUDE_CB(0)) dut1 (
    .clk_i(clk), .reset_i(rst_n[1]), .start_i(start[1]), .rf_addr_o(rf_addr[1]),
    .rf_data_i(rf_data[1]), .cb_data_i(cb_in[1]), .dump(dif1),
    .busy_o(busy[1]), .stall_o(stall[1]), .done_o(done[1]));

  assign rf_data[0] = rf[0][rf_addr[0]];
  assign rf_data[1] = rf[1][rf_addr[1]];
  assign dif0.ready = rdy[0];
  assign dif1.ready = rdy[1];
  assign vld[0] = dif0.valid;  assign vld[1] = dif1.valid;
  assign dat[0] = dif0.data;   assign dat[1] = dif1.data;
  assign adr[0] = dif0.addr;   assign adr[1] = dif1.addr;
  assign cbo[0] = dif0.cb;     assign cbo[1] = dif1.cb;
  assign lst[0] = dif0.last;   assign lst[1] = dif1.last;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("dut%0d_%s", d, s);
  endfunction

  // Model state: a dump is the ordered list of register beats (plus a CB beat on dut0).
  int            idx      [2];
  int            nb       [2];
  int            busy_len [2];
  int            last_len [2];
  int            dumps    [2];
  logic          exp_done [2];
  logic          prev_busy[2];
  logic          prev_vld [2];
  logic          prev_rdy [2];
  logic [DW-1:0] prev_dat [2];
  logic [AW-1:0] prev_adr [2];
  logic          prev_cb  [2];
  logic          prev_lst [2];
  logic [DW-1:0] snap     [2][NREG];
  logic          snap_cb  [2];

  task automatic mon_step(input int d);
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    logic          ec;
    logic          el;
    int            i;
    if (!rst_n[d]) begin
      idx[d] = 0;
      exp_done[d] = 1'b0;
      prev_busy[d] = 1'b0;
      prev_vld[d] = 1'b0;
      prev_rdy[d] = 1'b0;
      return;
    end
    check(tg(d, "stall_eq_busy"), stall[d], busy[d]);
    check(tg(d, "done_pulse"), done[d], exp_done[d]);
    if (done[d]) begin
      check(tg(d, "beats_per_dump"), idx[d], nb[d]);
      $display("dump dut%0d #%0d beats=%0d busy_cycles=%0d", d, dumps[d], idx[d], last_len[d]);
    end
    exp_done[d] = 1'b0;
    if (busy[d] && !prev_busy[d]) begin
      dumps[d]++;
      idx[d] = 0;
      busy_len[d] = 0;
      for (int k = 0; k < NREG; k++) snap[d][k] = rf[d][k];
      snap_cb[d] = cb_in[d];
    end
    if (busy[d]) busy_len[d]++;
    if (!busy[d]) check(tg(d, "valid_when_idle"), vld[d], 1'b0);
    if (prev_vld[d] && !prev_rdy[d]) begin
      check(tg(d, "hold_valid"), vld[d], 1'b1);
      check(tg(d, "hold_data"), dat[d], prev_dat[d]);
      check(tg(d, "hold_addr"), adr[d], prev_adr[d]);
      check(tg(d, "hold_cb"), cbo[d], prev_cb[d]);
      check(tg(d, "hold_last"), lst[d], prev_lst[d]);
    end
    if (vld[d] && rdy[d]) begin
      i = idx[d];
      check(tg(d, "beat_in_range"), (i < nb[d]), 1'b1);
      if (i < NREG) begin
        ea = AW'(i);
        ed = snap[d][i % NREG];
        ec = 1'b0;
      end else begin
        ea = '0;
        ed = DW'(snap_cb[d]);
        ec = 1'b1;
      end
      el = (i == nb[d] - 1);
      check(tg(d, "beat_addr"), adr[d], ea);
      check(tg(d, "beat_data"), dat[d], ed);
      check(tg(d, "beat_cb"), cbo[d], ec);
      check(tg(d, "beat_last"), lst[d], el);
      idx[d]++;
      if (idx[d] == nb[d]) begin
        exp_done[d] = 1'b1;
        last_len[d] = busy_len[d];
      end
    end
    prev_busy[d] = busy[d];
    prev_vld[d]  = vld[d];
    prev_rdy[d]  = rdy[d];
    prev_dat[d]  = dat[d];
    prev_adr[d]  = adr[d];
    prev_cb[d]   = cbo[d];
    prev_lst[d]  = lst[d];
  endtask

  // Observe both instances away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // Random back-pressure source, enabled per instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (rmode[d]) rdy[d] = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!done[d] && n < budget) begin
      tick();
      n++;
    end
    check(tg(d, "done_seen"), done[d], 1'b1);
  endtask

  task automatic wait_beat(input int d, input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (!(vld[d] && adr[d] == a) && n < budget) begin
      tick();
      n++;
    end
    check(tg(d, "beat_seen"), vld[d], 1'b1);
  endtask

  task automatic run_dump(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    wait_done(d, 400);
    tick();
  endtask

  task automatic randomize_rf(input int d);
    for (int k = 0; k < NREG; k++) rf[d][k] = 8'($urandom);
    cb_in[d] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int gap;
    int base;
    nb[0] = NREG + 1;
    nb[1] = NREG;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; rdy[d] = 1'b0; rmode[d] = 1'b0; cb_in[d] = 1'b0;
      dumps[d] = 0; last_len[d] = 0; busy_len[d] = 0; idx[d] = 0;
      for (int k = 0; k < NREG; k++) rf[d][k] = 8'(((k + 1) << 4) | (k + 1));
    end
    tick();
    tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check(tg(d, "rst_valid"), vld[d], 1'b0);
      check(tg(d, "rst_data"), dat[d], 8'h00);
      check(tg(d, "rst_addr"), adr[d], 3'd0);
      check(tg(d, "rst_cb_last"), {cbo[d], lst[d]}, 2'b00);
      check(tg(d, "rst_rf_addr"), rf_addr[d], 3'd0);
      check(tg(d, "rst_busy_stall_done"), {busy[d], stall[d], done[d]}, 3'b000);
    end

    // Known contents 11..88, cb=1, sink always ready; extra starts while busy and in DONE.
    cb_in[0] = 1'b1;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("dut0_busy_after_start", busy[0], 1'b1);
    repeat (4) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, 100);
    check("dut0_full_dump_cycles", last_len[0], 17);
    check("dut0_done_not_busy", busy[0], 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    check("dut0_start_ignored", dumps[0], 1);
    check("dut0_idle_busy", busy[0], 1'b0);
    check("dut0_rf_addr_no_wrap", rf_addr[0], 3'd7);

    // Back-pressure on register 2.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_beat(0, 3'd2, 50);
    rdy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("dut0_bp_valid", vld[0], 1'b1);
      check("dut0_bp_addr", adr[0], 3'd2);
      check("dut0_bp_data", dat[0], 8'h33);
    end
    rdy[0] = 1'b1;
    wait_done(0, 100);
    tick();
    check("dut0_bp_dumps", dumps[0], 2);

    // No condition-bit beat on the second instance.
    run_dump(1);
    check("dut1_full_dump_cycles", last_len[1], 16);
    check("dut1_dumps", dumps[1], 1);

    // Reset in the middle of a dump, then a fresh dump.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_beat(0, 3'd4, 50);
    tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    check("dut0_abort_valid", vld[0], 1'b0);
    check("dut0_abort_busy", busy[0], 1'b0);
    check("dut0_abort_done", done[0], 1'b0);
    check("dut0_abort_rf_addr", rf_addr[0], 3'd0);
    repeat (4) tick();
    check("dut0_abort_no_done", done[0], 1'b0);
    randomize_rf(0);
    run_dump(0);

    // start held high: back-to-back dumps separated by DONE and one IDLE cycle.
    base = dumps[0];
    start[0] = 1'b1;
    wait_done(0, 100);
    gap = 0;
    while (!busy[0] && gap < 10) begin
      tick();
      gap++;
    end
    check("dut0_restart_gap", gap, 2);
    wait_done(0, 100);
    start[0] = 1'b0;
    repeat (4) tick();
    check("dut0_held_start_dumps", dumps[0], base + 2);
    check("dut0_held_start_idle", busy[0], 1'b0);

    // Random contents and random back-pressure on both instances.
    rmode[0] = 1'b1;
    rmode[1] = 1'b1;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          randomize_rf(0);
          repeat ($urandom_range(0, 3)) tick();
          run_dump(0);
        end
      end
      begin
        for (int n = 0; n < 20; n++) begin
          randomize_rf(1);
          repeat ($urandom_range(0, 3)) tick();
          run_dump(1);
        end
      end
    join
    rmode[0] = 1'b0;
    rmode[1] = 1'b0;
    repeat (3) tick();
    check("dut0_total_dumps", dumps[0], base + 102);
    check("dut1_total_dumps", dumps[1], 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
